// File: rtl/alu32_pkg.sv
// alu32_pkg: opcode encoding and helpers shared by the alu32 slice
package alu32_pkg;

    typedef logic [3:0] opcode_t;

    localparam opcode_t OP_ADD = 4'b1100;
    localparam opcode_t OP_SUB = 4'b1110;
    localparam opcode_t OP_AND = 4'b0100;
    localparam opcode_t OP_OR  = 4'b0110;
    localparam opcode_t OP_NOR = 4'b1000;
    localparam opcode_t OP_XOR = 4'b1010;
    localparam opcode_t OP_SLL = 4'b0010;
    localparam opcode_t OP_SRL = 4'b0000;
    localparam opcode_t OP_SRA = 4'b0001;

    function automatic logic [31:0] rev32(input logic [31:0] d);
        for (int k = 0; k < 32; k++) rev32[k] = d[31-k];
    endfunction

endpackage

// File: rtl/alu32_shifter.sv
// alu32_shifter: 5-stage barrel shifter; left shifts reuse the right-shift stages on bit-reversed data
module alu32_shifter
    import alu32_pkg::*;
(
    input  logic [31:0] data,
    input  logic [4:0]  shAmt,
    input  logic        dir,
    input  logic        arith,
    output logic [31:0] result
);

    logic [5:0][31:0] stage;
    logic             fill;

    assign fill     = arith & ~dir & data[31];
    assign stage[0] = dir ? rev32(data) : data;

    genvar i;
    generate
        for (i = 0; i < 5; i++) begin : g_stage
            localparam int S = 1 << i;
            assign stage[i+1] = shAmt[i] ? {{S{fill}}, stage[i][31:S]} : stage[i];
        end
    endgenerate

    assign result = dir ? rev32(stage[5]) : stage[5];

endmodule

// File: rtl/alu32.sv
// alu32: single-cycle 32-bit ALU with a registered result
module alu32
    import alu32_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  opCode,
    input  logic [31:0] in1,
    input  logic [31:0] in2,
    input  logic [4:0]  shAmt,
    output logic [31:0] out
);

    opcode_t     op;
    logic        sub;
    logic [31:0] sum;
    logic [31:0] sh;
    logic [31:0] res;

    assign op  = opCode;
    assign sub = op == OP_SUB;

    alu32_shifter u_shifter (
        .data   (in1),
        .shAmt  (shAmt),
        .dir    (op == OP_SLL),
        .arith  (op == OP_SRA),
        .result (sh)
    );

    // shared adder: subtract as in1 + ~in2 + 1, then select the result by opcode
    always_comb begin
        sum = in1 + (sub ? ~in2 : in2) + {31'b0, sub};
        case (op)
            OP_ADD, OP_SUB:         res = sum;
            OP_AND:                 res = in1 & in2;
            OP_OR:                  res = in1 | in2;
            OP_NOR:                 res = ~(in1 | in2);
            OP_XOR:                 res = in1 ^ in2;
            OP_SLL, OP_SRL, OP_SRA: res = sh;
            default:                res = '0;
        endcase
    end

    // output register; reset wins over any opcode
    always_ff @(posedge clk) out <= rst ? '0 : res;

endmodule

// File: tb/tb_alu32.sv
// tb_alu32: scoreboard bench for alu32 with directed and random stimulus
module tb_alu32;

    logic        clk = 0;
    logic        rst = 1;
    logic [3:0]  opCode = 4'b1100;
    logic [31:0] in1 = 0, in2 = 0;
    logic [4:0]  shAmt = 0;
    logic [31:0] out;

    int checks = 0, passed = 0;
    logic [31:0] exp_q[$];
    string       name_q[$];

    alu32 dut (
        .clk(clk), .rst(rst), .opCode(opCode),
        .in1(in1), .in2(in2), .shAmt(shAmt), .out(out)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] model(input bit r, input logic [3:0] op,
                                          input logic [31:0] a, input logic [31:0] b,
                                          input logic [4:0] s);
        if (r) return 32'd0;
        case (op)
            4'b1100: return a + b;
            4'b1110: return a - b;
            4'b0100: return a & b;
            4'b0110: return a | b;
            4'b1000: return ~(a | b);
            4'b1010: return a ^ b;
            4'b0010: return a << s;
            4'b0000: return a >> s;
            4'b0001: return 32'($signed(a) >>> s);
            default: return 32'd0;
        endcase
    endfunction

    task automatic drive(input bit r, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] s, input string nm);
        @(negedge clk);
        rst = r; opCode = op; in1 = a; in2 = b; shAmt = s;
        exp_q.push_back(model(r, op, a, b, s));
        name_q.push_back(nm);
    endtask

    task automatic chk(input logic [31:0] e, input logic [31:0] v, input string nm);
        checks++;
        if (v === e) passed++;
        else $display("FAIL %s: out=%h expected=%h", nm, v, e);
    endtask

    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) chk(exp_q.pop_front(), out, name_q.pop_front());
    end

    initial begin
        logic [3:0] undef [7] = '{4'b0011, 4'b0101, 4'b0111, 4'b1001, 4'b1011, 4'b1101, 4'b1111};
        drive(1, 4'b1100, 5, 5, 0, "reset0");
        drive(1, 4'b1100, 5, 5, 0, "reset1");
        drive(0, 4'b1100, 5, 5, 0, "post_reset_add");
        drive(0, 4'b1100, 110, 10, 0, "add");
        drive(0, 4'b1110, 110, 10, 0, "sub");
        drive(0, 4'b1110, 10, 110, 0, "sub_wrap");
        drive(0, 4'b1100, 32'hFFFF_FFFF, 1, 0, "add_wrap");
        drive(0, 4'b0100, 110, 10, 0, "and");
        drive(0, 4'b0110, 110, 10, 0, "or");
        drive(0, 4'b1000, 110, 10, 0, "nor");
        drive(0, 4'b1010, 110, 10, 0, "xor");
        drive(0, 4'b0010, 14, 0, 2, "sll");
        drive(0, 4'b0000, 24, 0, 2, "srl");
        drive(0, 4'b0001, 120, 0, 2, "sra_pos");
        drive(0, 4'b0001, 32'h8000_000C, 0, 2, "sra_neg");
        drive(0, 4'b0000, 32'h8000_000C, 0, 2, "srl_neg");
        drive(0, 4'b0010, 32'h8000_0001, 0, 0, "sll0");
        drive(0, 4'b0000, 32'h8000_0001, 0, 0, "srl0");
        drive(0, 4'b0001, 32'h8000_0001, 0, 0, "sra0");
        drive(0, 4'b0010, 32'h8000_0001, 0, 31, "sll31");
        drive(0, 4'b0000, 32'h8000_0001, 0, 31, "srl31");
        drive(0, 4'b0001, 32'h8000_0001, 0, 31, "sra31");
        foreach (undef[k]) drive(0, undef[k], 32'h1234_5678, 32'h9ABC_DEF0, 3, "undef");
        drive(1, 4'b1010, 32'hFFFF_0000, 32'h0F0F_0F0F, 7, "reset_mid");
        for (int n = 0; n < 400; n++) begin
            logic [4:0] s;
            s = ($urandom_range(0, 3) == 0) ? ($urandom_range(0, 1) ? 5'd31 : 5'd0) : 5'($urandom);
            drive(($urandom_range(0, 49) == 0), 4'($urandom), $urandom, $urandom, s, "random");
        end
        @(negedge clk);
        for (int c = 0; c < 10 && exp_q.size() > 0; c++) @(negedge clk);
        if (exp_q.size() > 0) begin
            checks++;
            $display("FAIL drain: pending=%0d expected=0", exp_q.size());
        end
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
